// File: rtl/csi_pkg.sv
// csi_pkg: shared YUV422 widths, byte-lane order and output-stage state type
package csi_pkg;
  localparam int YUV_WORD_W = 64;
  localparam int YUV_PIXEL_W = 16;
  localparam int PIXEL_PER_WORD = 4;
  localparam logic [1:0] IDX_LAST = 2'(PIXEL_PER_WORD - 1);
  typedef enum logic {ST_IDLE, ST_SHIFT} stage_t;
  // Pixel idx of a word, MSB first: {Y0,U0},{Y1,V0},{Y2,U2},{Y3,V2}
  function automatic logic [YUV_PIXEL_W-1:0] pixel_sel(input logic [YUV_WORD_W-1:0] w, input logic [1:0] idx);
    return w[YUV_WORD_W-1-YUV_PIXEL_W*idx -: YUV_PIXEL_W];
  endfunction
endpackage

// File: rtl/yuv_output_serializer_if.sv
// yuv_output_serializer_if: word input and pixel output handshake bundle
interface yuv_output_serializer_if;
  import csi_pkg::*;
  logic [YUV_WORD_W-1:0] yuv_i;
  logic yuv_valid_i;
  logic [YUV_PIXEL_W-1:0] pixel_o;
  logic pixel_valid_o;
  logic pixel_ready_i;
  modport master (output yuv_i, yuv_valid_i, pixel_ready_i, input pixel_o, pixel_valid_o);
  modport slave (input yuv_i, yuv_valid_i, pixel_ready_i, output pixel_o, pixel_valid_o);
endinterface

// File: rtl/csi_sync_fifo.sv
// csi_sync_fifo: single-clock FIFO with registered count and synchronous flush
module csi_sync_fifo #(
  parameter int DW = 64,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty_o = wr == rd;
  assign full_o = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (flush_i || !full_o || do_pop);
  assign data_o = mem[rd[AW-1:0]];
  // Storage; a flush restarts at slot 0 so a coincident word becomes the only entry
  always_ff @(posedge clk_i)
    if (do_push) mem[flush_i ? '0 : wr[AW-1:0]] <= data_i;
  // Pointers and occupancy count
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      wr <= '0;
      rd <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr <= (AW+1)'(do_push);
      rd <= '0;
      count_o <= (AW+1)'(do_push);
    end else begin
      wr <= wr + (AW+1)'(do_push);
      rd <= rd + (AW+1)'(do_pop);
      count_o <= count_o + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/yuv_output_serializer.sv
// yuv_output_serializer: buffers 4-pixel YUV422 words and emits one 16-bit pixel per clock
module yuv_output_serializer
  import csi_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   frame_start_i,
  yuv_output_serializer_if.slave bus,
  output logic [FIFO_AW:0]       fifo_level_o,
  output logic                   overflow_o
);
  stage_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [YUV_WORD_W-1:0] word, word_n, head;
  logic full, empty, pop;
  csi_sync_fifo #(.DW(YUV_WORD_W), .AW(FIFO_AW)) u_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(frame_start_i),
    .push_i(bus.yuv_valid_i), .pop_i(pop), .data_i(bus.yuv_i),
    .data_o(head), .full_o(full), .empty_o(empty), .count_o(fifo_level_o)
  );
  assign bus.pixel_valid_o = state == ST_SHIFT;
  assign bus.pixel_o = bus.pixel_valid_o ? pixel_sel(word, idx) : '0;
  // Next stage state: load a word when idle or after the last pixel goes out; flush wins
  always_comb begin
    state_n = state;
    idx_n = idx;
    word_n = word;
    pop = 1'b0;
    if (frame_start_i) begin
      state_n = ST_IDLE;
      idx_n = '0;
    end else if (state == ST_IDLE || (bus.pixel_ready_i && idx == IDX_LAST)) begin
      pop = !empty;
      state_n = empty ? ST_IDLE : ST_SHIFT;
      idx_n = '0;
      word_n = empty ? word : head;
    end else if (bus.pixel_ready_i) begin
      idx_n = idx + 2'd1;
    end
  end
  // Output stage registers
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= ST_IDLE;
      idx <= '0;
      word <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      word <= word_n;
    end
  // Sticky drop flag: a word arriving at a full FIFO with no pop is lost
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) overflow_o <= 1'b0;
    else overflow_o <= !frame_start_i && (overflow_o || (bus.yuv_valid_i && full && !pop));
endmodule
